// File: rtl/fp_div.sv
// Multi-cycle IEEE-754 divider for single and half precision operands.
// Uses a radix-2 restoring mantissa divider that produces one quotient bit per clock.
module fp_div #(
    parameter logic [31:0] NAN32 = 32'h7FC00000,
    parameter logic [15:0] NAN16 = 16'h7E00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        precision,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        overflowFlag,
    output logic        divZeroFlag
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        DIV,
        NORM,
        DONE
    } state_t;

    localparam logic [4:0] LAST_ITER = 5'd24;

    state_t      state;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        prec_q;
    logic        sign_q;
    logic [7:0]  ea_q;
    logic [7:0]  eb_q;
    logic [23:0] mb_q;
    logic [24:0] r_q;
    logic [24:0] q_q;
    logic [4:0]  cnt;

    // Half operands are widened to the single layout so one classifier and divider serve both.
    function automatic logic [31:0] widen(input logic [31:0] x, input logic single);
        logic [7:0] e;
        if (single) begin
            widen = x;
        end else begin
            case (x[14:10])
                5'd0:    e = 8'd0;
                5'd31:   e = 8'd255;
                default: e = {3'b000, x[14:10]} + 8'd112;
            endcase
            widen = {x[15], e, x[9:0], 13'b0};
        end
    endfunction

    function automatic logic [31:0] pack_inf(input logic s, input logic single);
        pack_inf = single ? {s, 8'hFF, 23'b0} : {16'b0, s, 5'h1F, 10'b0};
    endfunction

    function automatic logic [31:0] pack_zero(input logic s, input logic single);
        pack_zero = single ? {s, 31'b0} : {16'b0, s, 15'b0};
    endfunction

    logic [31:0] ua;
    logic [31:0] ub;
    logic        a_zero, a_inf, a_nan;
    logic        b_zero, b_inf, b_nan;
    logic        sign_w;

    assign ua     = widen(a_q, prec_q);
    assign ub     = widen(b_q, prec_q);
    assign a_zero = (ua[30:23] == 8'h00);
    assign b_zero = (ub[30:23] == 8'h00);
    assign a_inf  = (ua[30:23] == 8'hFF) && (ua[22:0] == 23'b0);
    assign b_inf  = (ub[30:23] == 8'hFF) && (ub[22:0] == 23'b0);
    assign a_nan  = (ua[30:23] == 8'hFF) && (ua[22:0] != 23'b0);
    assign b_nan  = (ub[30:23] == 8'hFF) && (ub[22:0] != 23'b0);
    assign sign_w = ua[31] ^ ub[31];

    logic        is_special;
    logic [31:0] spec_res;
    logic        spec_ovf;
    logic        spec_dz;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        is_special = 1'b1;
        spec_res   = 32'b0;
        spec_ovf   = 1'b0;
        spec_dz    = 1'b0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_res = prec_q ? NAN32 : {16'b0, NAN16};
            spec_ovf = 1'b1;
        end else if (a_inf) begin
            spec_res = pack_inf(sign_w, prec_q);
            spec_ovf = 1'b1;
        end else if (b_zero) begin
            spec_res = pack_inf(sign_w, prec_q);
            spec_ovf = 1'b1;
            spec_dz  = 1'b1;
        end else if (a_zero || b_inf) begin
            spec_res = pack_zero(sign_w, prec_q);
        end else begin
            is_special = 1'b0;
        end
    end

    logic        q_bit;
    logic [24:0] r_diff;
    logic [24:0] r_next;

    assign r_diff = r_q - {1'b0, mb_q};
    assign q_bit  = (r_q >= {1'b0, mb_q});
    assign r_next = q_bit ? (r_diff << 1) : (r_q << 1);

    logic signed [9:0] exp_s;
    logic signed [9:0] exp_h;
    logic [22:0]       frac_n;
    logic [31:0]       norm_res;
    logic              norm_ovf;

    // The quotient lies in [0.5, 2); a leading integer bit costs one position and bumps the exponent.
    always_comb begin
        exp_s    = {2'b00, ea_q} - {2'b00, eb_q} + (q_q[24] ? 10'd127 : 10'd126);
        exp_h    = exp_s - 10'sd112;
        frac_n   = q_q[24] ? q_q[23:1] : q_q[22:0];
        norm_res = 32'b0;
        norm_ovf = 1'b0;
        if (prec_q) begin
            if (exp_s >= 10'sd255) begin
                norm_res = pack_inf(sign_q, 1'b1);
                norm_ovf = 1'b1;
            end else if (exp_s <= 10'sd0) begin
                norm_res = pack_zero(sign_q, 1'b1);
            end else begin
                norm_res = {sign_q, exp_s[7:0], frac_n};
            end
        end else begin
            if (exp_h >= 10'sd31) begin
                norm_res = pack_inf(sign_q, 1'b0);
                norm_ovf = 1'b1;
            end else if (exp_h <= 10'sd0) begin
                norm_res = pack_zero(sign_q, 1'b0);
            end else begin
                norm_res = {16'b0, sign_q, exp_h[4:0], frac_n[22:13]};
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            a_q          <= 32'b0;
            b_q          <= 32'b0;
            prec_q       <= 1'b0;
            sign_q       <= 1'b0;
            ea_q         <= 8'b0;
            eb_q         <= 8'b0;
            mb_q         <= 24'b0;
            r_q          <= 25'b0;
            q_q          <= 25'b0;
            cnt          <= 5'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result       <= 32'b0;
            overflowFlag <= 1'b0;
            divZeroFlag  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q    <= a;
                        b_q    <= b;
                        prec_q <= precision;
                        busy   <= 1'b1;
                        state  <= CHECK;
                    end
                end
                CHECK: begin
                    if (is_special) begin
                        result       <= spec_res;
                        overflowFlag <= spec_ovf;
                        divZeroFlag  <= spec_dz;
                        done         <= 1'b1;
                        state        <= DONE;
                    end else begin
                        sign_q <= sign_w;
                        ea_q   <= ua[30:23];
                        eb_q   <= ub[30:23];
                        mb_q   <= {1'b1, ub[22:0]};
                        r_q    <= {2'b01, ua[22:0]};
                        q_q    <= 25'b0;
                        cnt    <= 5'b0;
                        state  <= DIV;
                    end
                end
                DIV: begin
                    q_q <= {q_q[23:0], q_bit};
                    r_q <= r_next;
                    cnt <= cnt + 5'd1;
                    if (cnt == LAST_ITER) begin
                        state <= NORM;
                    end
                end
                NORM: begin
                    result       <= norm_res;
                    overflowFlag <= norm_ovf;
                    divZeroFlag  <= 1'b0;
                    done         <= 1'b1;
                    state        <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
